forward_ctrl: RTL and testbench

FORWARD_CTRL -- requirements
Module: forward_ctrl

---
 rtl/forward_ctrl.sv | 131 +++++++++++++
 tb/tb_forward_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/forward_ctrl.sv
// Hazard unit for a 5-stage pipeline: operand forwarding selects, load/branch
// interlocks, and a multi-cycle divider that holds the execute stage.
//
// state | meaning
// IDLE  | no divide in flight; a div_startE here launches one and stalls
// BUSY  | divider occupying execute; counter counts down to zero
// DONE  | one-cycle retire slot; stalls released, new starts ignored
module forward_ctrl #(
  parameter int unsigned DIV_LAT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       branchD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic       regwriteE,
  input  logic       memtoregE,
  input  logic [4:0] writeregM,
  input  logic       regwriteM,
  input  logic       memtoregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteW,
  input  logic       div_startE,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushE,
  output logic       flushM,
  output logic       div_busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  localparam logic [5:0] CNT_LOAD = 6'(DIV_LAT - 1);

  div_state_t state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic       divstall;
  logic       lwstall;
  logic       brstall;
  logic       m_valid, w_valid, e_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    divstall  = 1'b0;
    case (state)
      IDLE: begin
        if (div_startE) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_LOAD;
          divstall  = 1'b1;
        end
      end
      BUSY: begin
        divstall = 1'b1;
        if (cnt == 6'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 6'd1;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign div_busy = (state != IDLE);

  // register 0 is hardwired, so it never acts as a forwarding source
  assign m_valid = regwriteM && (writeregM != 5'd0);
  assign w_valid = regwriteW && (writeregW != 5'd0);
  assign e_valid = regwriteE && (writeregE != 5'd0);

  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (m_valid && writeregM == rsE)      forwardAE = 2'b10;
    else if (w_valid && writeregW == rsE) forwardAE = 2'b01;
    if (m_valid && writeregM == rtE)      forwardBE = 2'b10;
    else if (w_valid && writeregW == rtE) forwardBE = 2'b01;
  end

  assign forwardAD = m_valid && (writeregM == rsD);
  assign forwardBD = m_valid && (writeregM == rtD);

  assign lwstall = memtoregE && e_valid && (writeregE == rsD || writeregE == rtD);
  assign brstall = branchD &&
                   ((e_valid && (writeregE == rsD || writeregE == rtD)) ||
                    (memtoregM && writeregM != 5'd0 &&
                     (writeregM == rsD || writeregM == rtD)));

  // divider stall dominates: execute holds and memory gets the bubble instead
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    if (divstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (lwstall || brstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

endmodule

// File: tb/tb_forward_ctrl.sv
// Scoreboard bench for forward_ctrl: expected output vectors are queued as
// stimulus is applied and compared mid-cycle against the DUT.
module tb_forward_ctrl;

  localparam int unsigned DIV_LAT = 4;

  localparam logic [4:0] STL_NONE = 5'b00000;  // {stallF,stallD,stallE,flushE,flushM}
  localparam logic [4:0] STL_HAZ  = 5'b11010;
  localparam logic [4:0] STL_DIV  = 5'b11101;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       branchD, regwriteE, memtoregE, regwriteM, memtoregM, regwriteW, div_startE;
  logic [1:0] forwardAE, forwardBE;
  logic       forwardAD, forwardBD, stallF, stallD, stallE, flushE, flushM, div_busy;

  int n_checks = 0;
  int n_fails  = 0;

  logic [11:0] sb_q[$];
  string       tag_q[$];

  forward_ctrl #(.DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .branchD(branchD),
    .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .regwriteE(regwriteE), .memtoregE(memtoregE),
    .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .writeregW(writeregW), .regwriteW(regwriteW),
    .div_startE(div_startE),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushE(flushE), .flushM(flushM), .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got fAE=%b fBE=%b fAD=%b fBD=%b stl=%b busy=%b, want fAE=%b fBE=%b fAD=%b fBD=%b stl=%b busy=%b",
               tag, obs[11:10], obs[9:8], obs[7], obs[6], obs[5:1], obs[0],
               exp[11:10], exp[9:8], exp[7], exp[6], exp[5:1], exp[0]);
    end
  endtask

  function automatic logic [11:0] mk(input logic [1:0] fae, input logic [1:0] fbe,
                                     input logic fad, input logic fbd,
                                     input logic [4:0] stl, input logic busy);
    return {fae, fbe, fad, fbd, stl, busy};
  endfunction

  // Queue the expectation for the cycle just driven, then score at negedge.
  task automatic step(input string tag, input logic [11:0] exp);
    sb_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    check_eq(tag_q.pop_front(),
             {forwardAE, forwardBE, forwardAD, forwardBD,
              stallF, stallD, stallE, flushE, flushM, div_busy},
             sb_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rsD = 0; rtD = 0; branchD = 0; rsE = 0; rtE = 0;
    writeregE = 0; regwriteE = 0; memtoregE = 0;
    writeregM = 0; regwriteM = 0; memtoregM = 0;
    writeregW = 0; regwriteW = 0; div_startE = 0;
  endtask

  // Reference for the combinational part with the divider idle.
  function automatic logic [11:0] ref_comb();
    logic [1:0] fa, fb;
    logic       ad, bd, hz, e_hit, m_hit;
    fa = 2'b00;
    fb = 2'b00;
    if (regwriteW && writeregW != 0 && writeregW == rsE) fa = 2'b01;
    if (regwriteM && writeregM != 0 && writeregM == rsE) fa = 2'b10;
    if (regwriteW && writeregW != 0 && writeregW == rtE) fb = 2'b01;
    if (regwriteM && writeregM != 0 && writeregM == rtE) fb = 2'b10;
    ad = regwriteM && writeregM != 0 && writeregM == rsD;
    bd = regwriteM && writeregM != 0 && writeregM == rtD;
    e_hit = regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD);
    m_hit = memtoregM && writeregM != 0 && (writeregM == rsD || writeregM == rtD);
    hz = (memtoregE && e_hit) || (branchD && (e_hit || m_hit));
    return mk(fa, fb, ad, bd, hz ? STL_HAZ : STL_NONE, 1'b0);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("reset0", mk(2'b00, 2'b00, 0, 0, STL_NONE, 0));
    step("reset1", mk(2'b00, 2'b00, 0, 0, STL_NONE, 0));
    rst = 1'b0;

    // forwarding priority and register 0
    regwriteM = 1; writeregM = 5; regwriteW = 1; writeregW = 5; rsE = 5; rtE = 5;
    step("fwd_mem_prio", mk(2'b10, 2'b10, 0, 0, STL_NONE, 0));
    regwriteM = 0;
    step("fwd_wb", mk(2'b01, 2'b01, 0, 0, STL_NONE, 0));
    regwriteM = 1; writeregM = 0; writeregW = 0;
    step("fwd_dst0", mk(2'b00, 2'b00, 0, 0, STL_NONE, 0));
    rsE = 0; rtE = 0;
    step("fwd_r0_src", mk(2'b00, 2'b00, 0, 0, STL_NONE, 0));
    writeregM = 5; rsE = 5; writeregW = 7; rtE = 7;
    step("fwd_mixed", mk(2'b10, 2'b01, 0, 0, STL_NONE, 0));
    clear_inputs();

    // load-use interlock
    memtoregE = 1; regwriteE = 1; writeregE = 8; rtD = 8;
    step("lw_rt", mk(2'b00, 2'b00, 0, 0, STL_HAZ, 0));
    rtD = 0; rsD = 8;
    step("lw_rs", mk(2'b00, 2'b00, 0, 0, STL_HAZ, 0));
    writeregE = 0; rsD = 0; rtD = 0;
    step("lw_dst0", mk(2'b00, 2'b00, 0, 0, STL_NONE, 0));
    clear_inputs();

    // branch compare in decode
    branchD = 1; regwriteM = 1; writeregM = 3; rsD = 3; memtoregM = 0;
    step("br_fwd", mk(2'b00, 2'b00, 1, 0, STL_NONE, 0));
    memtoregM = 1;
    step("br_load_m", mk(2'b00, 2'b00, 1, 0, STL_HAZ, 0));
    clear_inputs();
    branchD = 1; regwriteE = 1; writeregE = 9; rtD = 9;
    step("br_alu_e", mk(2'b00, 2'b00, 0, 0, STL_HAZ, 0));
    branchD = 0;
    step("nobr_alu_e", mk(2'b00, 2'b00, 0, 0, STL_NONE, 0));
    clear_inputs();

    // single divide: start + DIV_LAT busy cycles, then DONE ignoring a start
    div_startE = 1;
    step("div_start", mk(2'b00, 2'b00, 0, 0, STL_DIV, 0));
    div_startE = 0;
    for (int i = 0; i < DIV_LAT; i++) step($sformatf("div_busy%0d", i), mk(2'b00, 2'b00, 0, 0, STL_DIV, 1));
    div_startE = 1;
    step("div_done", mk(2'b00, 2'b00, 0, 0, STL_NONE, 1));
    div_startE = 0;
    step("div_idle", mk(2'b00, 2'b00, 0, 0, STL_NONE, 0));

    // divide masks load-use stall; forwarding stays live
    div_startE = 1;
    step("dlw_start", mk(2'b00, 2'b00, 0, 0, STL_DIV, 0));
    div_startE = 0;
    memtoregE = 1; regwriteE = 1; writeregE = 8; rtD = 8;
    regwriteM = 1; writeregM = 5; rsE = 5;
    for (int i = 0; i < DIV_LAT; i++) step($sformatf("dlw_busy%0d", i), mk(2'b10, 2'b00, 0, 0, STL_DIV, 1));
    step("dlw_done", mk(2'b10, 2'b00, 0, 0, STL_HAZ, 1));
    clear_inputs();
    step("dlw_idle", mk(2'b00, 2'b00, 0, 0, STL_NONE, 0));

    // reset in the second busy cycle, then a full fresh divide
    div_startE = 1;
    step("rdiv_start", mk(2'b00, 2'b00, 0, 0, STL_DIV, 0));
    div_startE = 0;
    step("rdiv_busy0", mk(2'b00, 2'b00, 0, 0, STL_DIV, 1));
    rst = 1;
    step("rdiv_busy1_rst", mk(2'b00, 2'b00, 0, 0, STL_DIV, 1));
    rst = 0;
    step("rdiv_after_rst", mk(2'b00, 2'b00, 0, 0, STL_NONE, 0));
    div_startE = 1;
    step("rdiv_restart", mk(2'b00, 2'b00, 0, 0, STL_DIV, 0));
    div_startE = 0;
    for (int i = 0; i < DIV_LAT; i++) step($sformatf("rdiv_busy%0d", i), mk(2'b00, 2'b00, 0, 0, STL_DIV, 1));
    step("rdiv_done", mk(2'b00, 2'b00, 0, 0, STL_NONE, 1));
    step("rdiv_idle", mk(2'b00, 2'b00, 0, 0, STL_NONE, 0));

    // random combinational sweep, small register range for frequent hits
    for (int i = 0; i < 60; i++) begin
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3)); writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      branchD = 1'($urandom); regwriteE = 1'($urandom); memtoregE = 1'($urandom);
      regwriteM = 1'($urandom); memtoregM = 1'($urandom); regwriteW = 1'($urandom);
      step($sformatf("rand%0d", i), ref_comb());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
